// File: rtl/led_spi_pkg.sv
// Shared opcodes, default timing parameters and FSM state type for the LED SPI master.
package led_spi_pkg;

    localparam logic [7:0] CMD_TOGGLE = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_CLK_DIV    = 4;
    localparam int unsigned DEF_CS_GAP     = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

endpackage

// File: rtl/led_spi_if.sv
// Host-side command/response bundle of the LED SPI master.
interface led_spi_if
    import led_spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  cmd_rd;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  done;

    modport master (
        output cmd_valid, cmd_data, cmd_rd,
        input  cmd_ready, rsp_valid, rsp_data, done
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_rd,
        output cmd_ready, rsp_valid, rsp_data, done
    );
endinterface

// File: rtl/led_spi_master_clk_div.sv
// Half-period timer: tick on the last cycle of every CLK_DIV-cycle slot, first on its first cycle.
module spi_clk_div
    import led_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic CLK,
    input  logic RST,
    input  logic restart,
    output logic tick,
    output logic first
);
    localparam int unsigned W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick  = (cnt == LAST);
    assign first = (cnt == '0);

    always_ff @(posedge CLK) begin
        if (RST || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_spi_master.sv
// SPI mode-0 master: one command frame per host command, plus a response frame for reads.
module led_spi_master
    import led_spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned CS_GAP     = DEF_CS_GAP
) (
    input  logic     CLK,
    input  logic     RST,
    led_spi_if.slave host,
    output logic     SPI_CLK,
    output logic     SPI_CS,
    output logic     SPI_MOSI,
    input  logic     SPI_MISO
);
    localparam int unsigned BW = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned GW = $clog2(CS_GAP + 1);
    localparam logic [BW-1:0] BITS_ALL = BW'(DATA_WIDTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] tx, rx, rsp_data_q;
    logic [BW-1:0]         bit_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  rd_pend, in_resp;
    logic                  miso_s1, miso_s2;
    logic                  clk_q, cs_q, done_q, rsp_valid_q;
    logic                  tick, first, restart, ready, accept, gap_end;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .CLK     (CLK),
        .RST     (RST),
        .restart (restart),
        .tick    (tick),
        .first   (first)
    );

    assign ready          = (state == IDLE) && !done_q;
    assign accept         = host.cmd_valid && ready;
    assign gap_end        = (gap_cnt == GAP_LAST);
    assign host.cmd_ready = ready;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;
    assign host.done      = done_q;
    assign SPI_CLK        = clk_q;
    assign SPI_CS         = cs_q;
    assign SPI_MOSI       = tx[DATA_WIDTH-1] & ~cs_q;

    always_comb begin
        state_n = state;
        restart = 1'b0;
        case (state)
            IDLE:  if (accept) begin state_n = SETUP; restart = 1'b1; end
            SETUP: if (tick) state_n = HIGH;
            HIGH:  if (tick) state_n = LOW;
            LOW:   if (tick) state_n = (bit_cnt == BITS_ALL) ? HOLD : HIGH;
            HOLD:  if (tick) state_n = GAP;
            GAP: begin
                if (gap_end) begin
                    state_n = rd_pend ? SETUP : IDLE;
                    restart = rd_pend;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            tx          <= '0;
            rx          <= '0;
            rsp_data_q  <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            rd_pend     <= 1'b0;
            in_resp     <= 1'b0;
            miso_s1     <= 1'b0;
            miso_s2     <= 1'b0;
            clk_q       <= 1'b0;
            cs_q        <= 1'b1;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state       <= state_n;
            miso_s1     <= SPI_MISO;
            miso_s2     <= miso_s1;
            clk_q       <= (state_n == HIGH);
            cs_q        <= !(state_n inside {SETUP, HIGH, LOW, HOLD});
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            gap_cnt     <= (state == GAP && state_n == GAP) ? gap_cnt + 1'b1 : '0;
            if (accept) begin
                tx      <= host.cmd_data;
                rd_pend <= host.cmd_rd;
                in_resp <= 1'b0;
                bit_cnt <= '0;
            end
            if (state == HIGH && tick) begin
                tx      <= {tx[DATA_WIDTH-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
            // Sampling at the end of the first low cycle leaves the 2-flop
            // synchroniser enough settling time even when CLK_DIV is 2.
            if (state == LOW && first) begin
                rx <= {rx[DATA_WIDTH-2:0], miso_s2};
            end
            if (state == GAP && gap_end) begin
                if (rd_pend) begin
                    tx      <= '0;
                    rd_pend <= 1'b0;
                    in_resp <= 1'b1;
                    bit_cnt <= '0;
                end else begin
                    done_q      <= 1'b1;
                    rsp_valid_q <= in_resp;
                    if (in_resp) rsp_data_q <= rx;
                end
            end
        end
    end
endmodule

// File: tb/tb_led_spi_master.sv
// Bench for led_spi_master: 8-bit/CLK_DIV=4 and 16-bit/CLK_DIV=2 instances against a frame-level slave model.
module tb_led_spi_master;
    import led_spi_pkg::*;

    localparam int unsigned A_DW = 8, A_CD = 4, B_DW = 16, B_CD = 2, GAP_C = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic a_sclk, a_cs, a_mosi, a_miso;
    logic b_sclk, b_cs, b_mosi, b_miso;

    led_spi_if #(.DATA_WIDTH(A_DW)) a_if ();
    led_spi_if #(.DATA_WIDTH(B_DW)) b_if ();

    led_spi_master #(.DATA_WIDTH(A_DW), .CLK_DIV(A_CD), .CS_GAP(GAP_C)) dut_a (
        .CLK(CLK), .RST(RST), .host(a_if),
        .SPI_CLK(a_sclk), .SPI_CS(a_cs), .SPI_MOSI(a_mosi), .SPI_MISO(a_miso)
    );
    led_spi_master #(.DATA_WIDTH(B_DW), .CLK_DIV(B_CD), .CS_GAP(GAP_C)) dut_b (
        .CLK(CLK), .RST(RST), .host(b_if),
        .SPI_CLK(b_sclk), .SPI_CS(b_cs), .SPI_MOSI(b_mosi), .SPI_MISO(b_miso)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    // Slave model: records each CS-low frame, shifts its reply out on SPI_CLK rising edges.
    typedef struct {int k; logic [15:0] data; int edges; int len; int gap;} frame_t;
    frame_t fq[$];
    logic [15:0] rq0[$], rq1[$];
    logic [15:0] sh[2], cur[2];
    int   edges[2], len[2], hi_cnt[2], gap_cur[2], viol[2];
    logic pcs[2], psclk[2], miso_v[2];
    int   toggles = 0, exp_toggles = 0;
    logic [15:0] last_rsp[2];

    assign a_miso = miso_v[0];
    assign b_miso = miso_v[1];

    function automatic int dw_of(input int k); return (k == 0) ? A_DW : B_DW; endfunction
    function automatic int cd_of(input int k); return (k == 0) ? A_CD : B_CD; endfunction

    task automatic mon_step(input int k, input logic cs, input logic sclk, input logic mosi);
        int dw = dw_of(k);
        if (cs && sclk) viol[k]++;
        if (!cs) begin
            if (pcs[k]) begin
                sh[k] = '0; edges[k] = 0; len[k] = 0; miso_v[k] = 1'b0;
                gap_cur[k] = hi_cnt[k];
                if (k == 0) cur[k] = (rq0.size() > 0) ? rq0.pop_front() : 16'h0;
                else        cur[k] = (rq1.size() > 0) ? rq1.pop_front() : 16'h0;
            end
            len[k]++;
            hi_cnt[k] = 0;
            if (sclk && !psclk[k]) begin
                sh[k] = {sh[k][14:0], mosi};
                miso_v[k] = cur[k][dw-1-edges[k]];
                edges[k]++;
            end
        end else begin
            if (!pcs[k]) begin
                fq.push_back('{k, sh[k], edges[k], len[k], gap_cur[k]});
                if (k == 0 && edges[k] == A_DW && sh[k][7:0] == CMD_TOGGLE) toggles++;
            end
            hi_cnt[k]++;
        end
        pcs[k] = cs;
        psclk[k] = sclk;
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            for (int k = 0; k < 2; k++) begin
                pcs[k] = 1'b1; psclk[k] = 1'b0; miso_v[k] = 1'b0; hi_cnt[k] = 0;
            end
        end else begin
            mon_step(0, a_cs, a_sclk, a_mosi);
            mon_step(1, b_cs, b_sclk, b_mosi);
        end
    end

    typedef struct packed {
        logic ready, rsp_valid, done, sclk, cs, mosi;
        logic [15:0] rsp_data;
    } obs_t;

    function automatic obs_t obs(input int k);
        obs_t o;
        if (k == 0) begin
            o.ready = a_if.cmd_ready; o.rsp_valid = a_if.rsp_valid; o.done = a_if.done;
            o.sclk = a_sclk; o.cs = a_cs; o.mosi = a_mosi; o.rsp_data = 16'(a_if.rsp_data);
        end else begin
            o.ready = b_if.cmd_ready; o.rsp_valid = b_if.rsp_valid; o.done = b_if.done;
            o.sclk = b_sclk; o.cs = b_cs; o.mosi = b_mosi; o.rsp_data = b_if.rsp_data;
        end
        return o;
    endfunction

    task automatic drive(input int k, input logic v, input logic [15:0] d, input logic r);
        if (k == 0) begin a_if.cmd_valid = v; a_if.cmd_data = d[7:0]; a_if.cmd_rd = r; end
        else        begin b_if.cmd_valid = v; b_if.cmd_data = d;      b_if.cmd_rd = r; end
    endtask

    // One host transaction; expected frames and timing come from the transaction-level rules.
    task automatic run_txn(input int k, input logic [15:0] d, input logic rd, input logic [15:0] reply,
                           input int exp_lat, input bit hold, input string tag);
        logic [15:0] mask = (k == 0) ? 16'h00ff : 16'hffff;
        int   tf = (2 * dw_of(k) + 2) * cd_of(k);
        int   nfr = rd ? 2 : 1;
        int   t0, lat = -1, rdy_bad = 0, rsp_cnt = 0;
        logic rsp_at_done = 1'b0;
        logic [15:0] rsp_got = '0;
        obs_t o;
        fq.delete();
        if (k == 0) begin rq0.delete(); rq0.push_back(16'($urandom) & mask); if (rd) rq0.push_back(reply & mask); end
        else        begin rq1.delete(); rq1.push_back(16'($urandom) & mask); if (rd) rq1.push_back(reply & mask); end
        @(negedge CLK);
        o = obs(k);
        chk({tag, "_ready"}, 32'(o.ready), 32'd1);
        drive(k, 1'b1, d, rd);
        t0 = cyc;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            if (c == 0 && !hold) drive(k, 1'b0, 16'($urandom), 1'($urandom));
            o = obs(k);
            if (o.ready) rdy_bad++;
            if (o.rsp_valid) rsp_cnt++;
            if (o.done) begin
                lat = cyc - t0;
                rsp_at_done = o.rsp_valid;
                rsp_got = o.rsp_data;
                break;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rspcnt"}, 32'(rsp_cnt), 32'(rd));
        chk({tag, "_rspv_at_done"}, 32'(rsp_at_done), 32'(rd));
        if (rd) begin
            chk({tag, "_rsp_data"}, 32'(rsp_got), 32'(reply & mask));
            last_rsp[k] = reply & mask;
        end else begin
            chk({tag, "_rsp_hold"}, 32'(o.rsp_data), 32'(last_rsp[k]));
        end
        chk({tag, "_busy_ready"}, 32'(rdy_bad), 32'd0);
        chk({tag, "_nframes"}, 32'(fq.size()), 32'(nfr));
        for (int i = 0; i < fq.size() && i < nfr; i++) begin
            chk({tag, "_mosi"}, 32'(fq[i].data), (i == 0) ? 32'(d & mask) : 32'd0);
            chk({tag, "_edges"}, 32'(fq[i].edges), 32'(dw_of(k)));
            chk({tag, "_cs_len"}, 32'(fq[i].len), 32'(tf));
            if (i == 1) chk({tag, "_cs_gap"}, 32'(fq[i].gap), 32'(GAP_C));
        end
        if (k == 0 && d[7:0] == CMD_TOGGLE && lat == exp_lat) exp_toggles++;
    endtask

    typedef struct {int k; logic [15:0] data; logic rd; logic [15:0] reply; int lat; string name;} vec_t;
    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   found;
        int   pulses;
        obs_t o;
        drive(0, 1'b0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 1'b0);
        last_rsp[0] = '0; last_rsp[1] = '0;
        viol[0] = 0; viol[1] = 0;

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            o = obs(k);
            chk("rst_cs", 32'(o.cs), 32'd1);
            chk("rst_sclk", 32'(o.sclk), 32'd0);
            chk("rst_mosi", 32'(o.mosi), 32'd0);
            chk("rst_ready", 32'(o.ready), 32'd1);
            chk("rst_pulses", 32'({o.rsp_valid, o.done}), 32'd0);
            chk("rst_rsp_data", 32'(o.rsp_data), 32'd0);
        end
        RST = 1'b0;

        vecs[0] = '{0, 16'h0001, 1'b0, 16'h0000,  77, "wr_toggle"};
        vecs[1] = '{0, 16'h0002, 1'b1, 16'h00A5, 153, "rd_a5"};
        vecs[2] = '{0, 16'h00FF, 1'b0, 16'h0000,  77, "wr_ff"};
        vecs[3] = '{0, 16'h0080, 1'b1, 16'h0000, 153, "rd_zero"};
        vecs[4] = '{0, 16'h0002, 1'b1, 16'h00FF, 153, "rd_ff"};
        vecs[5] = '{1, 16'h0002, 1'b1, 16'hBEEF, 145, "b_rd_beef"};
        vecs[6] = '{1, 16'h8001, 1'b0, 16'h0000,  73, "b_wr"};
        foreach (vecs[i]) run_txn(vecs[i].k, vecs[i].data, vecs[i].rd, vecs[i].reply, vecs[i].lat, 1'b0, vecs[i].name);

        // cmd_valid held across a whole transaction: the next accept lands the cycle after done.
        run_txn(0, 16'h0001, 1'b0, 16'h0, 77, 1'b1, "hold1");
        run_txn(0, 16'h0001, 1'b0, 16'h0, 77, 1'b0, "hold2");

        // Reset during bit 4 of a frame.
        rq0.delete();
        @(negedge CLK);
        drive(0, 1'b1, 16'h0001, 1'b0);
        @(negedge CLK);
        drive(0, 1'b0, 16'h0, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge CLK);
            if (edges[0] == 4 && !a_cs) found = 1'b1;
        end
        chk("midrst_reach_bit4", 32'(found), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        o = obs(0);
        chk("midrst_cs", 32'(o.cs), 32'd1);
        chk("midrst_sclk", 32'(o.sclk), 32'd0);
        chk("midrst_ready", 32'(o.ready), 32'd1);
        RST = 1'b0;
        last_rsp[0] = '0; last_rsp[1] = '0;
        pulses = 0;
        repeat (160) begin
            @(negedge CLK);
            o = obs(0);
            if (o.done || o.rsp_valid || !o.cs) pulses++;
        end
        chk("midrst_no_done", 32'(pulses), 32'd0);
        fq.delete();
        run_txn(0, 16'h0001, 1'b0, 16'h0, 77, 1'b0, "after_rst");

        // Randomized transactions; expected latency from the frame-count rule.
        for (int i = 0; i < 12; i++) begin
            int   k = int'($urandom_range(0, 1));
            logic rd = 1'($urandom_range(0, 1));
            int   tf = (2 * dw_of(k) + 2) * cd_of(k);
            int   nfr = rd ? 2 : 1;
            run_txn(k, 16'($urandom), rd, 16'($urandom), 1 + nfr * (tf + GAP_C), 1'b0, "rand");
        end

        chk("slave_toggles", 32'(toggles), 32'(exp_toggles));
        chk("a_sclk_cs_high", 32'(viol[0]), 32'd0);
        chk("b_sclk_cs_high", 32'(viol[1]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
